// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults, ALU operation codes and the
// forwarding-select encoding used by the EX operand stage.
package cpu_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_AW_DEFAULT = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_fwd_sel.sv
// Forwarding decision for one source operand: the younger EX/MEM result wins
// over MEM/WB, and register 0 is never forwarded.
module fwd_sel
    import cpu_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] src_addr_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    output fwd_sel_e          sel_o
);

    always_comb begin
        sel_o = FWD_NONE;
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src_addr_i)) begin
            sel_o = FWD_EXMEM;
        end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src_addr_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Edge priority is reset, then flush, then stall, then load.
module ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic              alu_src_i,
    input  logic [2:0]        alu_ctrl_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              mem_to_reg_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [2:0]        ALUCtrl_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_to_reg_o,
    output logic              valid_o,
    output logic              load_use_o
);

    logic              valid_q,      valid_d;
    logic [DATA_W-1:0] rs1_data_q,   rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q,   rs2_data_d;
    logic [REG_AW-1:0] rs1_addr_q,   rs1_addr_d;
    logic [REG_AW-1:0] rs2_addr_q,   rs2_addr_d;
    logic [DATA_W-1:0] imm_q,        imm_d;
    logic              alu_src_q,    alu_src_d;
    logic [2:0]        alu_ctrl_q,   alu_ctrl_d;
    logic [REG_AW-1:0] rd_addr_q,    rd_addr_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;

    fwd_sel_e          rs1_sel;
    fwd_sel_e          rs2_sel;
    logic [DATA_W-1:0] rs1_fwd;
    logic [DATA_W-1:0] rs2_fwd;

    // Holding is the default; flush wins over stall so a bubble always lands.
    always_comb begin
        valid_d      = valid_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        rs1_addr_d   = rs1_addr_q;
        rs2_addr_d   = rs2_addr_q;
        imm_d        = imm_q;
        alu_src_d    = alu_src_q;
        alu_ctrl_d   = alu_ctrl_q;
        rd_addr_d    = rd_addr_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        if (flush_i) begin
            valid_d      = 1'b0;
            rs1_data_d   = '0;
            rs2_data_d   = '0;
            rs1_addr_d   = '0;
            rs2_addr_d   = '0;
            imm_d        = '0;
            alu_src_d    = 1'b0;
            alu_ctrl_d   = '0;
            rd_addr_d    = '0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else if (!stall_i) begin
            valid_d      = valid_i;
            rs1_data_d   = rs1_data_i;
            rs2_data_d   = rs2_data_i;
            rs1_addr_d   = rs1_addr_i;
            rs2_addr_d   = rs2_addr_i;
            imm_d        = imm_i;
            alu_src_d    = alu_src_i;
            alu_ctrl_d   = alu_ctrl_i;
            rd_addr_d    = rd_addr_i;
            reg_write_d  = reg_write_i  & valid_i;
            mem_read_d   = mem_read_i   & valid_i;
            mem_write_d  = mem_write_i  & valid_i;
            mem_to_reg_d = mem_to_reg_i & valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q      <= 1'b0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            imm_q        <= '0;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= '0;
            rd_addr_q    <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
            imm_q        <= imm_d;
            alu_src_q    <= alu_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rd_addr_q    <= rd_addr_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs1 (
        .src_addr_i        (rs1_addr_q),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .sel_o             (rs1_sel)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs2 (
        .src_addr_i        (rs2_addr_q),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .sel_o             (rs2_sel)
    );

    always_comb begin
        case (rs1_sel)
            FWD_EXMEM: rs1_fwd = exmem_data_i;
            FWD_MEMWB: rs1_fwd = memwb_data_i;
            default:   rs1_fwd = rs1_data_q;
        endcase
        case (rs2_sel)
            FWD_EXMEM: rs2_fwd = exmem_data_i;
            FWD_MEMWB: rs2_fwd = memwb_data_i;
            default:   rs2_fwd = rs2_data_q;
        endcase
    end

    assign data1_o      = rs1_fwd;
    assign data2_o      = alu_src_q ? imm_q : rs2_fwd;
    assign store_data_o = rs2_fwd;
    assign ALUCtrl_o    = alu_ctrl_q;
    assign rd_addr_o    = rd_addr_q;
    assign reg_write_o  = reg_write_q;
    assign mem_read_o   = mem_read_q;
    assign mem_write_o  = mem_write_q;
    assign mem_to_reg_o = mem_to_reg_q;
    assign valid_o      = valid_q;

    // A load in EX whose result is needed by the live instruction in ID.
    assign load_use_o = valid_q && mem_read_q && (rd_addr_q != '0) && valid_i &&
                        ((rd_addr_q == rs1_addr_i) || (rd_addr_q == rs2_addr_i));

endmodule
